parallel_to_serial_tx: RTL and testbench
========================================

PARALLEL_TO_SERIAL_TX -- requirements
Module: parallel_to_serial_tx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the parallel word width in bits (legal 2..32).
REQ-002 Parameter BIT_CYCLES, default 4, SHALL set the number of clock cycles per serial bit (legal 1..65535).
REQ-003 Parameter MSB_FIRST, default 1, SHALL select the data bit order (1 = bit DATA_W-1 first, 0 = bit 0 first).
REQ-004 CLOCK_50_B5B  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 RESET_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 data_in  input  DATA_W  SHALL carry the parallel word to transmit.
REQ-007 load  input  1  SHALL request transmission of data_in.
REQ-008 ready  output  1  SHALL indicate that a load will be accepted this cycle.
REQ-009 serial_out  output  1  SHALL be the registered serial line (idle high).
REQ-010 busy  output  1  SHALL be high while a frame is being shifted out.
REQ-011 done  output  1  SHALL pulse high for exactly one cycle at the end of each frame.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-013 Frame format SHALL be: one start bit (0), DATA_W data bits in MSB_FIRST order, one stop bit (1), each held for BIT_CYCLES cycles.
REQ-014 ready SHALL be 1 only in IDLE; busy SHALL be the inverse of ready.
REQ-015 A load SHALL be accepted at a rising edge when load=1 and ready=1; data_in SHALL be captured into an internal shift register at that edge.
REQ-016 A load SHALL be ignored when ready=0; the frame in progress and the captured word SHALL be unaffected.
REQ-017 Changes on data_in after acceptance SHALL NOT affect the frame in progress.
REQ-018 On acceptance the FSM SHALL go IDLE->START and serial_out SHALL be 0 from the cycle following the accepting edge (latency 1 cycle).
REQ-019 A bit-cycle counter SHALL count 0..BIT_CYCLES-1 and wrap to 0; each state transition and each bit advance SHALL occur only on the wrap.
REQ-020 START->DATA SHALL occur after BIT_CYCLES cycles; DATA SHALL present DATA_W bits, tracked by a bit index counting 0..DATA_W-1.
REQ-021 DATA->STOP SHALL occur when the bit index equals DATA_W-1 and the bit-cycle counter wraps.
REQ-022 STOP->IDLE SHALL occur after BIT_CYCLES cycles; done SHALL be 1 during the last cycle of the stop bit only.
REQ-023 Total frame length from first start-bit cycle to last stop-bit cycle SHALL be (DATA_W+2)*BIT_CYCLES cycles.
REQ-024 After STOP at least one IDLE cycle (ready=1, serial_out=1) SHALL occur before the next start bit; load held continuously high SHALL produce back-to-back frames separated by exactly one idle cycle.
REQ-025 With BIT_CYCLES=1 the counter SHALL be constant 0 and every cycle SHALL be a wrap.
REQ-026 serial_out SHALL be driven from a flip-flop, never combinationally from load or data_in.

Reset
REQ-027 While RESET_n=0: state=IDLE, serial_out=1, ready=1, busy=0, done=0, all counters and the shift register=0.
REQ-028 Assertion of RESET_n mid-frame SHALL immediately abort the frame and force the reset values; no done pulse SHALL be generated for the aborted frame.
REQ-029 After RESET_n deasserts, the first load SHALL be accepted no earlier than the first rising edge with RESET_n=1.

Verification
REQ-030 DATA_W=8, BIT_CYCLES=4, MSB_FIRST=1, load 0xA5 -> serial_out 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then 1 for 4 cycles; done on cycle 40; ready high on cycle 41.
REQ-031 Same config, MSB_FIRST=0, load 0x01 -> data bits 1,0,0,0,0,0,0,0 after the start bit; frame length 40 cycles.
REQ-032 load 0x3C accepted, then load=1 with data_in=0xFF at cycle 10 -> ignored; transmitted bits remain 0,0,1,1,1,1,0,0.
REQ-033 load held high with data 0x55 then 0xAA -> two complete frames, exactly one idle-high cycle between stop bit and next start bit, two done pulses 41 cycles apart.
REQ-034 RESET_n pulsed low at cycle 17 of a frame -> serial_out=1, ready=1, busy=0 asynchronously; no done; next load transmits a full correct frame.
REQ-035 BIT_CYCLES=1, DATA_W=4, load 0x9 -> serial_out sequence 0,1,0,0,1,1 on consecutive cycles, done on the 6th.

Source files
------------

// File: rtl/parallel_to_serial_tx.sv
// parallel_to_serial_tx
//   Framed serial transmitter. A parallel word is captured on load and sent as
//   one start bit (0), DATA_W data bits, and one stop bit (1). Each bit is held
//   for BIT_CYCLES clocks. The line idles high.
//
// Parameters
//   DATA_W     parallel word width (2..32)
//   BIT_CYCLES clocks per serial bit (1..65535)
//   MSB_FIRST  1: bit DATA_W-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   CLOCK_50_B5B  in   clock; all state updates on its rising edge
//   RESET_n       in   asynchronous active-low reset
//   data_in       in   word to transmit, sampled only on the accepting edge
//   load          in   transmit request, honoured only while ready=1
//   ready         out  high in IDLE: a load is accepted this cycle
//   serial_out    out  registered serial line
//   busy          out  inverse of ready; high while a frame is in progress
//   done          out  one-cycle pulse during the last cycle of the stop bit
module parallel_to_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic              CLOCK_50_B5B,
  input  logic              RESET_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              serial_out,
  output logic              busy,
  output logic              done
);

  // A one-cycle bit still needs a 1-bit counter so the wrap compare is legal.
  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  // Counter value one cycle before the final stop-bit cycle; done is
  // registered, so it must be set up one cycle ahead.
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'((BIT_CYCLES > 1) ? (BIT_CYCLES - 2) : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  // With one cycle per bit the stop bit is a single cycle, so done has to be
  // raised on the very edge that enters STOP.
  localparam logic DONE_ON_ENTRY = (BIT_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  bit_idx_reg;
  logic [DATA_W-1:0] shift_data_reg;
  logic              serial_out_reg;
  logic              done_reg;

  logic [DATA_W-1:0] load_word;
  logic              cnt_wrap;

  // The shift register always shifts towards its MSB. For LSB-first order the
  // word is bit-reversed on capture so the same shifter serves both orders.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_order
      if (MSB_FIRST != 0) begin : g_msb
        assign load_word[gi] = data_in[gi];
      end else begin : g_lsb
        assign load_word[gi] = data_in[DATA_W-1-gi];
      end
    end
  endgenerate

  assign cnt_wrap = (cnt_reg == CNT_LAST);

  always_ff @(posedge CLOCK_50_B5B or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_data_reg <= '0;
      serial_out_reg <= 1'b1;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg     <= '0;
          bit_idx_reg <= '0;
          if (load) begin
            shift_data_reg <= load_word;
            serial_out_reg <= 1'b0;
            state_reg      <= START;
          end
        end

        START: begin
          if (cnt_wrap) begin
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            serial_out_reg <= shift_data_reg[DATA_W-1];
            shift_data_reg <= {shift_data_reg[DATA_W-2:0], 1'b0};
            state_reg      <= DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (cnt_wrap) begin
            cnt_reg <= '0;
            if (bit_idx_reg == IDX_LAST) begin
              serial_out_reg <= 1'b1;
              done_reg       <= DONE_ON_ENTRY;
              state_reg      <= STOP;
            end else begin
              bit_idx_reg    <= bit_idx_reg + 1'b1;
              serial_out_reg <= shift_data_reg[DATA_W-1];
              shift_data_reg <= {shift_data_reg[DATA_W-2:0], 1'b0};
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        STOP: begin
          if (cnt_wrap) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            done_reg <= (cnt_reg == CNT_PRE);
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready      = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign serial_out = serial_out_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Bench for parallel_to_serial_tx. Three instances cover MSB-first 8x4,
// LSB-first 8x4 and MSB-first 4x1. Each instance has a frame-level model:
// an accepted load expands into the list of per-cycle {serial, done} values
// the frame must show, and an idle cycle is whatever remains when that list
// is empty. Directed scenarios add hand-computed literal checks.
module tb_parallel_to_serial_tx;

  logic        clk = 1'b0;
  logic [2:0]  rst_v = 3'b000;
  logic [2:0]  load_v = 3'b000;
  logic [31:0] data_v [3];
  logic [2:0]  ser_v, rdy_v, bsy_v, dn_v;

  int total = 0;
  int bad   = 0;

  logic ser_rec [1:100];
  logic rdy_rec [1:100];
  logic dn_rec  [1:100];

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int DW = (gi == 2) ? 4 : 8;
      localparam int BC = (gi == 2) ? 1 : 4;
      localparam int MF = (gi == 1) ? 0 : 1;

      parallel_to_serial_tx #(
        .DATA_W(DW),
        .BIT_CYCLES(BC),
        .MSB_FIRST(MF)
      ) u_dut (
        .CLOCK_50_B5B(clk),
        .RESET_n     (rst_v[gi]),
        .data_in     (data_v[gi][DW-1:0]),
        .load        (load_v[gi]),
        .ready       (rdy_v[gi]),
        .serial_out  (ser_v[gi]),
        .busy        (bsy_v[gi]),
        .done        (dn_v[gi])
      );

      // Expected {serial_out, done} for every remaining cycle of the frame.
      logic [1:0] q [$];

      always @(posedge clk or negedge rst_v[gi]) begin
        logic [31:0] w;
        if (!rst_v[gi]) begin
          q.delete();
        end else if (q.size() != 0) begin
          void'(q.pop_front());
        end else if (load_v[gi]) begin
          w = data_v[gi];
          for (int k = 0; k < BC; k++) q.push_back(2'b00);
          for (int b = 0; b < DW; b++) begin
            for (int k = 0; k < BC; k++)
              q.push_back({w[(MF != 0) ? (DW - 1 - b) : b], 1'b0});
          end
          for (int k = 0; k < BC; k++) q.push_back({1'b1, (k == BC - 1)});
        end
      end

      always @(negedge clk) begin
        logic [3:0] exp_v;
        if (q.size() != 0) exp_v = {q[0][1], 1'b0, 1'b1, q[0][0]};
        else               exp_v = 4'b1100;
        check($sformatf("u%0d_cycle_ser_rdy_bsy_done", gi),
              {28'd0, ser_v[gi], rdy_v[gi], bsy_v[gi], dn_v[gi]}, {28'd0, exp_v});
      end
    end
  endgenerate

  // Must be entered at posedge+1 with the instance idle. Accepts word d on the
  // next edge, then records n cycles (cycle 1 = first start-bit cycle).
  // mode 1: extra load of 0xFF in cycle 10; mode 2: load held high, data
  // switched to 0xAA; mode 3: reset pulse in cycle 17.
  task automatic run_frame(input int i, input logic [31:0] d, input int n, input int mode);
    load_v[i] = 1'b1;
    data_v[i] = d;
    @(posedge clk); #1;
    if (mode != 2) load_v[i] = 1'b0;
    for (int c = 1; c <= n; c++) begin
      if (mode == 1 && c == 10) begin load_v[i] = 1'b1; data_v[i] = 32'hFF; end
      if (mode == 1 && c == 11) load_v[i] = 1'b0;
      if (mode == 2 && c == 1)  data_v[i] = 32'hAA;
      if (mode == 2 && c == 42) load_v[i] = 1'b0;
      if (mode == 3 && c == 17) begin
        rst_v[i] = 1'b0;
        #1;
        check("abort_async_ser_rdy_bsy_done",
              {28'd0, ser_v[i], rdy_v[i], bsy_v[i], dn_v[i]}, 32'hC);
      end
      if (mode == 3 && c == 18) rst_v[i] = 1'b1;
      @(negedge clk);
      ser_rec[c] = ser_v[i];
      rdy_rec[c] = rdy_v[i];
      dn_rec[c]  = dn_v[i];
      @(posedge clk); #1;
    end
  endtask

  // fr[9] is the start bit, fr[0] the stop bit; 4 cycles per bit.
  task automatic check_frame(input string nm, input logic [9:0] fr, input int off);
    for (int c = 1; c <= 40; c++)
      check($sformatf("%s_c%0d", nm, c), {31'd0, ser_rec[off + c]}, {31'd0, fr[9 - (c - 1) / 4]});
  endtask

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (dn_rec[c]) n++;
    return n;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) data_v[i] = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_u%0d", i), {28'd0, ser_v[i], rdy_v[i], bsy_v[i], dn_v[i]}, 32'hC);
    @(posedge clk); #1;
    rst_v = 3'b111;
    @(posedge clk); #1;

    // 0xA5, MSB first, 4 cycles per bit
    run_frame(0, 32'hA5, 42, 0);
    check_frame("a5_msb", 10'b0_10100101_1, 0);
    check("a5_done_c39", {31'd0, dn_rec[39]}, 32'd0);
    check("a5_done_c40", {31'd0, dn_rec[40]}, 32'd1);
    check("a5_ready_c40", {31'd0, rdy_rec[40]}, 32'd0);
    check("a5_ready_c41", {31'd0, rdy_rec[41]}, 32'd1);

    // 0x01, LSB first
    run_frame(1, 32'h01, 42, 0);
    check_frame("01_lsb", 10'b0_10000000_1, 0);
    check("01_done_c40", {31'd0, dn_rec[40]}, 32'd1);
    check("01_ready_c41", {31'd0, rdy_rec[41]}, 32'd1);
    check("01_done_count", count_done(1, 42), 32'd1);

    // 0x3C with a 0xFF load attempted mid-frame
    run_frame(0, 32'h3C, 42, 1);
    check_frame("3c_ignore_ff", 10'b0_00111100_1, 0);

    // load held high: 0x55 then 0xAA back to back
    run_frame(0, 32'h55, 84, 2);
    check_frame("b2b_55", 10'b0_01010101_1, 0);
    check_frame("b2b_aa", 10'b0_10101010_1, 41);
    check("b2b_idle_ser_c41", {31'd0, ser_rec[41]}, 32'd1);
    check("b2b_idle_rdy_c41", {31'd0, rdy_rec[41]}, 32'd1);
    check("b2b_done_c40", {31'd0, dn_rec[40]}, 32'd1);
    check("b2b_done_c81", {31'd0, dn_rec[81]}, 32'd1);
    check("b2b_done_count", count_done(1, 84), 32'd2);

    // reset mid-frame, then a clean frame
    run_frame(0, 32'hC3, 42, 3);
    check("abort_done_count", count_done(1, 42), 32'd0);
    check("abort_ready_c20", {31'd0, rdy_rec[20]}, 32'd1);
    run_frame(0, 32'h96, 42, 0);
    check_frame("after_abort_96", 10'b0_10010110_1, 0);
    check("after_abort_done_c40", {31'd0, dn_rec[40]}, 32'd1);

    // 4-bit word, one cycle per bit
    run_frame(2, 32'h9, 8, 0);
    begin
      logic [5:0] seq;
      seq = 6'b010011;
      for (int c = 1; c <= 6; c++)
        check($sformatf("bc1_ser_c%0d", c), {31'd0, ser_rec[c]}, {31'd0, seq[6 - c]});
    end
    check("bc1_done_c5", {31'd0, dn_rec[5]}, 32'd0);
    check("bc1_done_c6", {31'd0, dn_rec[6]}, 32'd1);
    check("bc1_ready_c7", {31'd0, rdy_rec[7]}, 32'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
